nco_zq: RTL and testbench
=========================

# nco_zq

Quadrature numerically-controlled oscillator: the generating end of the zero/quad DLL loop. A phase accumulator advanced by a programmable increment drives two square-wave outputs, `zero_o` and `quad_o`, with `quad_o` lagging `zero_o` by 90 degrees. This is exactly the edge pattern the quadrature phase detector/integrator consumes, so the two blocks close the loop. Frequency words are double-buffered and applied only at phase wrap, and start/stop are phase-aligned, so output cycles are never truncated or glitched.

## Interface
- `FREQ_W`, 8, increment word width (bits).
- `ACCUM_W`, 10, phase accumulator width (bits); must be >= `FREQ_W` and >= 2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `en_i` in 1: run request, level.
- `freq_i` in `FREQ_W`: increment word.
- `freq_vld_i` in 1: write strobe for `freq_i`, one cycle per write.
- `zero_o` out 1: in-phase square wave.
- `quad_o` out 1: quadrature square wave.
- `cyc_o` out 1: one-cycle pulse on each accumulator wrap.
- `busy_o` out 1: high when state is not IDLE.

## Operation
- Registers:
  - `shadow`: written every cycle that `freq_vld_i`=1.
  - `inc`: active increment, zero-extended to `ACCUM_W`.
  - `accum`: `ACCUM_W` bits.
  - `state`: IDLE, RUN or STOP.
- Accumulate, in RUN/STOP only: `{carry, accum} <= accum + inc`. Overflow wraps modulo 2^`ACCUM_W`. A wrap is `carry`=1.
- Decode, with p = `accum[ACCUM_W-1:ACCUM_W-2]`:
  - `zero_o` = p[1]^p[0]; `quad_o` = p[1].
  - Quadrant sequence is 0,1,2,3 = (zero,quad) 00, 10, 11, 01.
  - Event order is zero rise → quad rise → zero fall → quad fall.
  - Both outputs are flops loaded with the decode of the *new* accum value, so they change on the same edge as `accum`. No combinational path reaches any output.
- IDLE:
  - `accum`=0 and outputs low.
  - If `en_i`=1: go to RUN and load `inc <= freq_vld_i ? freq_i : shadow`. `accum` does not advance on this edge.
- RUN:
  - Accumulate every cycle.
  - On a wrap edge, `inc` reloads from `freq_vld_i ? freq_i : shadow`. A write on the wrap cycle takes effect immediately (bypass).
  - If `en_i`=0: go to STOP. The accumulate still occurs on that edge.
- STOP:
  - Accumulate every cycle; `inc` is held (no reload).
  - On a wrap edge: go to IDLE and force `accum`=0, outputs 0. `cyc_o` still pulses.
  - If `en_i` returns to 1 before the wrap: go back to RUN with no phase disturbance.
  - If `inc`=0: go to IDLE on the next edge with `accum`=0, so the block never hangs.
- `inc`=0 in RUN: `accum` is frozen and outputs hold static. This is legal.
- Output frequency = f_clk·inc/2^`ACCUM_W`.

## Timing
- Reset values: all outputs 0, `accum`/`inc`/`shadow`=0, state IDLE. Reset overrides everything, including mid-cycle and a simultaneous `freq_vld_i`.
- Latency:
  - `en_i` sampled high in IDLE (edge 0) → first accumulate at edge 1.
  - `freq_vld_i` → the new increment is used from the first accumulate after the next wrap, or at start.
- `cyc_o` is high for exactly the cycle following a wrap edge, registered alongside `accum`.
- `busy_o` rises on the edge leaving IDLE. It falls on the same edge that zeros `accum` in STOP.
- Simultaneous cases:
  - Wrap and `en_i`=0 in RUN: reload happens, then state goes to STOP. The stop completes at the following wrap.
  - `freq_vld_i` during STOP: `shadow` updates and is used at the next start.

## Test plan
- Reset, then `freq_i`=64 with vld, then `en_i`=1 (`ACCUM_W`=10):
  - `zero_o` rises 4 accumulates after start.
  - `quad_o` rises 4 later.
  - Period is 16 cycles.
  - `cyc_o` pulses every 16 cycles.
  - Outputs follow 00→10→11→01.
- While running at 64, write 128 at mid-cycle: the current period stays 16 cycles, then the period becomes 8 from the next wrap. Repeat the test with the write on the exact wrap cycle: the new period takes effect immediately.
- Drop `en_i` at quadrant 1:
  - Outputs complete the cycle.
  - `busy_o` falls at the wrap.
  - `accum`=0 and outputs stay low.
  - Re-raising `en_i` before the wrap instead keeps running uninterrupted.
- `inc`=0 while running: outputs freeze and `cyc_o` stays low. Then drop `en_i`: IDLE is reached in 1 cycle.
- `inc`=255 (max): the accumulator wraps modulo 1024 and every wrap reloads correctly. Check `cyc_o` count against the expected 255/1024 ratio over 4096 cycles.
- Assert `rst_i` for one cycle mid-run: on the next edge all outputs and registers are 0 and state is IDLE, and the block restarts cleanly on `en_i`.

Source files
------------

// File: rtl/nco_zq_if.sv
// Control and output bundle of the quadrature NCO: run request, frequency
// write port, and the registered zero/quad square waves with status.
interface nco_zq_if #(
  parameter int unsigned FREQ_W = 8
);
  logic              en_i;
  logic [FREQ_W-1:0] freq_i;
  logic              freq_vld_i;
  logic              zero_o;
  logic              quad_o;
  logic              cyc_o;
  logic              busy_o;

  modport master (
    output en_i, freq_i, freq_vld_i,
    input  zero_o, quad_o, cyc_o, busy_o
  );

  modport slave (
    input  en_i, freq_i, freq_vld_i,
    output zero_o, quad_o, cyc_o, busy_o
  );
endinterface

// File: rtl/nco_zq.sv
// Quadrature NCO: phase accumulator with wrap-aligned frequency reload and
// phase-aligned start/stop, decoding the top two phase bits to zero/quad.
module nco_zq #(
  parameter int unsigned FREQ_W  = 8,
  parameter int unsigned ACCUM_W = 10
) (
  input  logic      clk_i,
  input  logic      rst_i,
  nco_zq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t              state_q, state_d;
  logic [FREQ_W-1:0]   shadow_q, shadow_d;
  logic [ACCUM_W-1:0]  inc_q, inc_d;
  logic [ACCUM_W-1:0]  accum_q, accum_d;
  logic [ACCUM_W-1:0]  load_inc;
  logic [ACCUM_W:0]    sum;
  logic                carry;
  logic [1:0]          quadrant;
  logic                cyc_d;
  logic                zero_q, quad_q, cyc_q, busy_q;

  assign sum      = {1'b0, accum_q} + {1'b0, inc_q};
  assign carry    = sum[ACCUM_W];
  // A write on the same cycle as a reload bypasses the shadow register
  assign load_inc = bus.freq_vld_i ? ACCUM_W'(bus.freq_i) : ACCUM_W'(shadow_q);
  assign quadrant = accum_d[ACCUM_W-1 -: 2];

  // Next-state, accumulator and increment update
  always_comb begin
    state_d  = state_q;
    inc_d    = inc_q;
    accum_d  = accum_q;
    cyc_d    = 1'b0;
    shadow_d = bus.freq_vld_i ? bus.freq_i : shadow_q;

    case (state_q)
      IDLE: begin
        accum_d = '0;
        if (bus.en_i) begin
          state_d = RUN;
          inc_d   = load_inc;
        end
      end
      RUN: begin
        accum_d = sum[ACCUM_W-1:0];
        cyc_d   = carry;
        if (carry) begin
          inc_d = load_inc;
        end
        if (!bus.en_i) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // A zero increment would never wrap, so leave immediately
        if (inc_q == '0) begin
          state_d = IDLE;
          accum_d = '0;
        end else if (carry) begin
          state_d = IDLE;
          accum_d = '0;
          cyc_d   = 1'b1;
        end else begin
          accum_d = sum[ACCUM_W-1:0];
          if (bus.en_i) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        accum_d = '0;
      end
    endcase
  end

  // State and registered outputs, decoded from the new phase value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      inc_q    <= '0;
      accum_q  <= '0;
      zero_q   <= 1'b0;
      quad_q   <= 1'b0;
      cyc_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      inc_q    <= inc_d;
      accum_q  <= accum_d;
      zero_q   <= quadrant[1] ^ quadrant[0];
      quad_q   <= quadrant[1];
      cyc_q    <= cyc_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.zero_o = zero_q;
  assign bus.quad_o = quad_q;
  assign bus.cyc_o  = cyc_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_nco_zq.sv
// Bench for nco_zq: hand-derived start-up table, directed loop scenarios, and
// randomized traffic against a phase/quadrant reference model.
module tb_nco_zq;
  localparam int unsigned FREQ_W  = 8;
  localparam int unsigned ACCUM_W = 10;
  localparam int FULL = 1 << ACCUM_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nco_zq_if #(.FREQ_W(FREQ_W)) bus ();

  nco_zq #(.FREQ_W(FREQ_W), .ACCUM_W(ACCUM_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;

  // Reference model: integer phase, mode 0=idle 1=run 2=stop
  int m_phase = 0, m_inc = 0, m_shadow = 0, m_mode = 0;
  bit m_cyc = 1'b0;

  function automatic void model_step(bit en, int freq, bit vld, bit r);
    int total;
    int pick;
    if (r) begin
      m_phase = 0; m_inc = 0; m_shadow = 0; m_mode = 0; m_cyc = 1'b0;
      return;
    end
    pick  = vld ? freq : m_shadow;
    m_cyc = 1'b0;
    total = m_phase + m_inc;
    case (m_mode)
      0: begin
        m_phase = 0;
        if (en) begin m_mode = 1; m_inc = pick; end
      end
      1: begin
        m_phase = total % FULL;
        if (total >= FULL) begin m_cyc = 1'b1; m_inc = pick; end
        if (!en) m_mode = 2;
      end
      default: begin
        if (m_inc == 0) begin
          m_mode = 0; m_phase = 0;
        end else if (total >= FULL) begin
          m_mode = 0; m_phase = 0; m_cyc = 1'b1;
        end else begin
          m_phase = total;
          if (en) m_mode = 1;
        end
      end
    endcase
    if (vld) m_shadow = freq;
  endfunction

  function automatic void check(string name, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cycle, got, exp);
    end
  endfunction

  function automatic logic [3:0] dut_out();
    return {bus.zero_o, bus.quad_o, bus.cyc_o, bus.busy_o};
  endfunction

  function automatic logic [3:0] model_out();
    int q;
    q = m_phase / (FULL / 4);
    return {((q == 1) || (q == 2)), (q >= 2), m_cyc, (m_mode != 0)};
  endfunction

  // One clock: model samples the same inputs as the DUT, outputs compared after the edge
  task automatic tick();
    logic [3:0] got, exp;
    @(posedge clk);
    model_step(bus.en_i, int'(bus.freq_i), bus.freq_vld_i, rst);
    #1;
    cycle++;
    got = dut_out();
    exp = model_out();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL model_out @cycle %0d: {zero,quad,cyc,busy} got %b, expected %b",
               cycle, got, exp);
    end
  endtask

  task automatic run_until_cyc(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cyc_o && n < limit);
    if (!bus.cyc_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL cyc_timeout @cycle %0d: no cyc_o within %0d cycles", cycle, limit);
    end
  endtask

  typedef struct {
    bit       en;
    bit [7:0] freq;
    bit       vld;
    bit       r;
    bit [3:0] exp;   // {zero, quad, cyc, busy}
  } vec_t;

  vec_t tbl[20];

  initial begin
    bit [3:0] exps[20];
    int n, k, cnt;

    bus.en_i = 1'b0;
    bus.freq_i = '0;
    bus.freq_vld_i = 1'b0;

    // Start at inc=64: phase advances 64/edge, quadrant changes every 4 edges
    exps = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
             4'b1001, 4'b1001, 4'b1001, 4'b1001,
             4'b1101, 4'b1101, 4'b1101, 4'b1101,
             4'b0101, 4'b0101, 4'b0101, 4'b0101,
             4'b0011, 4'b0001};
    for (int i = 0; i < 20; i++) begin
      tbl[i].r    = (i == 0);
      tbl[i].vld  = (i == 1);
      tbl[i].freq = (i == 0) ? 8'd0 : 8'd64;
      tbl[i].en   = (i >= 2);
      tbl[i].exp  = exps[i];
    end

    for (int i = 0; i < 20; i++) begin
      rst            = tbl[i].r;
      bus.en_i       = tbl[i].en;
      bus.freq_i     = tbl[i].freq;
      bus.freq_vld_i = tbl[i].vld;
      tick();
      check($sformatf("table[%0d]", i), int'(dut_out()), int'(tbl[i].exp));
    end
    rst = 1'b0;
    bus.freq_vld_i = 1'b0;

    // Mid-period write: current period stays 16, next is 8
    run_until_cyc(40, n);
    repeat (5) tick();
    bus.freq_i = 8'd128; bus.freq_vld_i = 1'b1;
    tick();
    bus.freq_vld_i = 1'b0;
    run_until_cyc(40, n);
    check("mid_write_period", 6 + n, 16);
    run_until_cyc(40, n);
    check("new_period", n, 8);

    // Write exactly on the wrap edge takes effect immediately
    repeat (7) tick();
    bus.freq_i = 8'd64; bus.freq_vld_i = 1'b1;
    tick();
    bus.freq_vld_i = 1'b0;
    check("wrap_write_cyc", int'(bus.cyc_o), 1);
    run_until_cyc(40, n);
    check("bypass_period", n, 16);

    // Drop en in quadrant 1: cycle completes, busy falls at the wrap
    repeat (5) tick();
    check("q1_zero", int'(bus.zero_o), 1);
    bus.en_i = 1'b0;
    run_until_cyc(40, n);
    check("stop_len", n, 11);
    check("stop_busy", int'(bus.busy_o), 0);
    check("stop_zero", int'(bus.zero_o), 0);
    repeat (5) tick();
    check("idle_busy", int'(bus.busy_o), 0);

    // Re-raise en before the wrap: no phase disturbance
    bus.en_i = 1'b1;
    tick();
    run_until_cyc(40, n);
    check("restart_period", n, 16);
    repeat (5) tick();
    bus.en_i = 1'b0;
    tick(); tick();
    bus.en_i = 1'b1;
    tick();
    k = 8;
    run_until_cyc(40, n);
    check("reraise_period", k + n, 16);
    check("reraise_busy", int'(bus.busy_o), 1);
    run_until_cyc(40, n);
    check("reraise_next", n, 16);

    // inc=0 while running: frozen, no cyc; stop reaches IDLE one edge after STOP
    bus.freq_i = 8'd0; bus.freq_vld_i = 1'b1;
    tick();
    bus.freq_vld_i = 1'b0;
    run_until_cyc(40, n);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(bus.cyc_o);
    end
    check("zero_inc_cyc", cnt, 0);
    check("zero_inc_busy", int'(bus.busy_o), 1);
    bus.en_i = 1'b0;
    tick();
    check("zero_inc_stop", int'(bus.busy_o), 1);
    tick();
    check("zero_inc_idle", int'(bus.busy_o), 0);

    // Max increment: 4096 accumulates of 255 give 1020 wraps
    bus.freq_i = 8'd255; bus.freq_vld_i = 1'b1;
    tick();
    bus.freq_vld_i = 1'b0;
    bus.en_i = 1'b1;
    tick();
    cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      cnt += int'(bus.cyc_o);
    end
    check("max_inc_wraps", cnt, 1020);

    // Reset mid-run beats a simultaneous write; restart afterwards
    rst = 1'b1; bus.freq_i = 8'd33; bus.freq_vld_i = 1'b1;
    tick();
    rst = 1'b0; bus.freq_vld_i = 1'b0;
    check("rst_outputs", int'(dut_out()), 0);
    tick();
    check("rst_shadow_cleared_busy", int'(bus.busy_o), 1);
    bus.en_i = 1'b0;
    tick(); tick();
    check("rst_back_idle", int'(bus.busy_o), 0);
    bus.freq_i = 8'd64; bus.freq_vld_i = 1'b1; bus.en_i = 1'b1;
    tick();
    bus.freq_vld_i = 1'b0;
    repeat (3) tick();
    check("restart_zero_pre", int'(bus.zero_o), 0);
    tick();
    check("restart_zero_rise", int'(bus.zero_o), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(39) == 0) bus.en_i = ~bus.en_i;
      bus.freq_vld_i = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) bus.freq_i = FREQ_W'($urandom_range(8));
      else                        bus.freq_i = FREQ_W'($urandom_range(255));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
